// File: rtl/pip_operand_fetch_if.sv
// Issue-stage bundle: instruction in, operands out to the ALU,
// result writeback in, and the hazard-stall counter out.
interface pip_operand_fetch_if #(
  parameter int DATA_W = 4,
  parameter int AW     = 3,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [11:0]       in_instr;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [2:0]        out_op;
  logic [AW-1:0]     out_rd;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  stall_cnt;

  // Upstream/ALU side driving the operand fetch stage
  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_op, out_rd, stall_cnt
  );

  // The operand fetch stage itself
  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, out_a, out_b, out_op, out_rd, stall_cnt
  );
endinterface

// File: rtl/pip_operand_fetch.sv
// Operand fetch / issue stage for the 4-bit pipelined ALU.
// Reads rs1/rs2 from a small register file with same-cycle writeback
// bypass, interlocks RAW/WAW hazards with a per-register busy scoreboard,
// and presents the operands through a registered valid/ready output.
module pip_operand_fetch #(
  parameter int DATA_W = 4,
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pip_operand_fetch_if.slave   bus
);

  logic [DATA_W-1:0] rf_reg [NREG];
  logic [NREG-1:0]   busy_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_a_reg;
  logic [DATA_W-1:0] out_b_reg;
  logic [2:0]        out_op_reg;
  logic [AW-1:0]     out_rd_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic [2:0]        op;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [NREG-1:0]   wb_clr;
  logic              hazard;
  logic              space;
  logic              ready;
  logic              accept;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  assign op  = bus.in_instr[11:9];
  assign rd  = bus.in_instr[8:6];
  assign rs1 = bus.in_instr[5:3];
  assign rs2 = bus.in_instr[2:0];

  // A writeback landing this cycle releases its register immediately
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_wb_clr
      assign wb_clr[gi] = bus.wb_en && (bus.wb_addr == AW'(gi));
    end
  endgenerate

  // Hazard detection, readiness and bypassed operand reads
  always_comb begin
    hazard = ((rs1 != '0) && busy_reg[rs1] && !wb_clr[rs1]) ||
             ((rs2 != '0) && busy_reg[rs2] && !wb_clr[rs2]) ||
             ((rd  != '0) && busy_reg[rd]  && !wb_clr[rd]);
    space  = !out_valid_reg || bus.out_ready;
    ready  = space && !hazard;
    accept = bus.in_valid && ready;
    rs1_val = (rs1 == '0) ? '0 : (wb_clr[rs1] ? bus.wb_data : rf_reg[rs1]);
    rs2_val = (rs2 == '0) ? '0 : (wb_clr[rs2] ? bus.wb_data : rf_reg[rs2]);
  end

  // Register file, scoreboard, output stage and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
      busy_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_op_reg    <= '0;
      out_rd_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      // Writeback first so a same-cycle accept to the same rd re-sets busy
      if (bus.wb_en && (bus.wb_addr != '0)) begin
        rf_reg[bus.wb_addr]   <= bus.wb_data;
        busy_reg[bus.wb_addr] <= 1'b0;
      end
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_a_reg     <= rs1_val;
        out_b_reg     <= rs2_val;
        out_op_reg    <= op;
        out_rd_reg    <= rd;
        if (rd != '0) busy_reg[rd] <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
      // Only hazard stalls are counted, not back-pressure
      if (bus.in_valid && space && hazard && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_a     = out_a_reg;
  assign bus.out_b     = out_b_reg;
  assign bus.out_op    = out_op_reg;
  assign bus.out_rd    = out_rd_reg;
  assign bus.stall_cnt = stall_cnt_reg;

endmodule
